resize_sequencer: RTL and testbench
===================================

RESIZE_SEQUENCER -- requirements
Module: resize_sequencer

Interface
REQ-001 SHALL have parameters: IMG_W 160, source width in pixels.
REQ-002 SHALL have parameter IMG_H 120, source height; FB_W 320, frame-buffer width; FB_H 240, frame-buffer height.
REQ-003 SHALL have parameter PIPE_LAT 2, the cycles from base_read_addr issue to the datapath pixel being valid (ROM 1 plus datapath 1).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 start  in  1  single-cycle request to process one frame.
REQ-007 mode  in  2  00 copy 1:1, 01 zoom-in 2x nearest, 10 zoom-in 2x interpolated, 11 zoom-out 2x average.
REQ-008 base_read_addr  out  16  source address of the top-left pixel of the 2x2 window.
REQ-009 edge_x, edge_y  out  1 each  window column/row lies on the last source column/row; datapath replicates.
REQ-010 phase_x, phase_y  out  1 each  sub-pixel phase for interpolation; aligned with base_read_addr.
REQ-011 wren  out  1  frame-buffer write enable.
REQ-012 write_addr  out  17  frame-buffer write address.
REQ-013 fill_zero  out  1  selects constant 0 as frame-buffer data during clear.
REQ-014 busy  out  1  high while a frame is in progress.
REQ-015 done  out  1  one-cycle completion pulse.

Function
REQ-016 SHALL use FSM states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-017 IDLE + start SHALL latch mode and go to CLEAR when mode is 00 or 11; for other modes it SHALL go to RUN.
REQ-018 CLEAR SHALL assert wren and fill_zero for FB_W*FB_H cycles, with write_addr 0..76799, then go to RUN.
REQ-019 RUN SHALL step output coordinates (ox,oy), raster order, one per cycle: 160x120 for mode 00, 320x240 for modes 01/10, 80x60 for mode 11.
REQ-020 Source coordinates SHALL be: (ox,oy) for mode 00; (ox>>1, oy>>1) for modes 01/10; (2*ox, 2*oy) for mode 11; base_read_addr = sy*IMG_W + sx.
REQ-021 phase_x = ox[0] and phase_y = oy[0] in modes 01/10; both SHALL be 0 otherwise.
REQ-022 edge_x SHALL be high when sx = IMG_W-1 and edge_y when sy = IMG_H-1; each SHALL be low otherwise.
REQ-023 Destination write_addr SHALL be (oy+offy)*FB_W + (ox+offx), with offsets (80,60) for mode 00, (0,0) for modes 01/10, and (120,90) for mode 11; arithmetic is 17 bits with no overflow.
REQ-024 In RUN, valid and the destination address SHALL be delayed PIPE_LAT cycles, so wren/write_addr lag the read address by exactly PIPE_LAT.
REQ-025 After the last coordinate is issued, RUN SHALL go to DRAIN, which flushes PIPE_LAT cycles; then DONE.
REQ-026 DONE SHALL pulse done for 1 cycle and return to IDLE; busy SHALL be high from the cycle after accepted start through DONE inclusive.
REQ-027 start while busy SHALL be ignored; mode changes after latch SHALL be ignored.
REQ-028 start in the same cycle as DONE SHALL be ignored; a new start is accepted only in IDLE.
REQ-029 wren SHALL never be high in IDLE or DONE; fill_zero SHALL be high only in CLEAR.

Reset
REQ-030 Reset SHALL force IDLE, clear all counters and pipeline valids, and drive every output to 0, including mid-CLEAR or mid-RUN; no write follows deassertion.

Structure
REQ-031 Dimension constants, mode encodings and state encoding SHALL live in a shared package, resize_pkg, used also by ZoomSelection.
REQ-032 A sub-module, coord_counter (x/y raster counter with programmable limits and last flag), SHALL be used for both CLEAR and RUN.

Verification
REQ-033 Mode 01 start -> no CLEAR; first wren 2 cycles after first address; write_addr 0..76799; done at cycle 76800+2+1; total 76800 writes.
REQ-034 Mode 00 -> 76800 zero writes, then 19200 writes; first data write_addr = 60*320+80 = 19280; last = 179*320+239 = 57519.
REQ-035 Mode 11 -> base_read_addr steps 0,2,4..; row 1 begins at 320; first data write_addr = 90*320+120 = 28920; 4800 data writes.
REQ-036 Mode 10 at ox=319, oy=239 -> base_read_addr = 119*160+159 = 19199, edge_x = edge_y = 1, phase_x = phase_y = 1.
REQ-037 Reset asserted mid-RUN at write 1000 -> next cycle all outputs 0, IDLE; a subsequent start completes normally.
REQ-038 start pulsed while busy and on the DONE cycle -> no restart; exactly one done per accepted start.

Source files
------------

// File: rtl/resize_pkg.sv
// Shared constants and encodings for the resize sequencer.
// Dimensions, mode encodings and FSM state encoding.
package resize_pkg;

  localparam int IMG_W_DEF    = 160;
  localparam int IMG_H_DEF    = 120;
  localparam int FB_W_DEF     = 320;
  localparam int FB_H_DEF     = 240;
  localparam int PIPE_LAT_DEF = 2;

  localparam int RADDR_W = 16;
  localparam int WADDR_W = 17;

  typedef enum logic [1:0] {
    MODE_COPY = 2'b00,
    MODE_NEAR = 2'b01,
    MODE_LERP = 2'b10,
    MODE_AVG  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // Copy and zoom-out leave a border, so the frame buffer is cleared first.
  function automatic logic needs_clear(mode_e m);
    return (m == MODE_COPY) || (m == MODE_AVG);
  endfunction

endpackage

// File: rtl/resize_sequencer_coord_counter.sv
// Raster x/y counter with programmable last indices.
// Shared by the frame-buffer clear and the resize scan.
module coord_counter #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  input  logic [XW-1:0] x_last,
  input  logic [YW-1:0] y_last,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  assign last = (x == x_last) && (y == y_last);

  // Step in raster order; clear wins over step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x == x_last) begin
        x <= '0;
        y <= (y == y_last) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/resize_sequencer.sv
// Frame resize sequencer: clears the frame buffer, scans output
// coordinates, issues source reads and delayed frame-buffer writes.
module resize_sequencer
  import resize_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int FB_W     = FB_W_DEF,
  parameter int FB_H     = FB_H_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic [RADDR_W-1:0] base_read_addr,
  output logic               edge_x,
  output logic               edge_y,
  output logic               phase_x,
  output logic               phase_y,
  output logic               wren,
  output logic [WADDR_W-1:0] write_addr,
  output logic               fill_zero,
  output logic               busy,
  output logic               done
);

  localparam int XW = $clog2(FB_W) + 1;
  localparam int YW = $clog2(FB_H) + 1;
  localparam int DW = $clog2(PIPE_LAT + 1);

  localparam int unsigned CP_OX = (FB_W - IMG_W) / 2;
  localparam int unsigned CP_OY = (FB_H - IMG_H) / 2;
  localparam int unsigned AV_OX = (FB_W - IMG_W / 2) / 2;
  localparam int unsigned AV_OY = (FB_H - IMG_H / 2) / 2;
  localparam int unsigned SX_LAST = IMG_W - 1;
  localparam int unsigned SY_LAST = IMG_H - 1;

  state_e        state;
  mode_e         mode_q;
  logic [DW-1:0] drain_cnt;

  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic [XW-1:0] x_last;
  logic [YW-1:0] y_last;
  logic          cnt_last;
  logic          cnt_clear;
  logic          cnt_step;
  logic          run;

  int unsigned   ox, oy, sx, sy, dx, dy;
  logic          zoom;
  logic [WADDR_W-1:0] dst;
  logic [WADDR_W-1:0] clr_addr;

  logic [PIPE_LAT-1:0] pv;
  logic [WADDR_W-1:0]  pa [PIPE_LAT];

  assign run       = (state == S_RUN);
  assign cnt_clear = (state == S_IDLE) || ((state == S_CLEAR) && cnt_last);
  assign cnt_step  = (state == S_CLEAR) || run;

  // Scan limits: full frame buffer while clearing, output size while running.
  always_comb begin
    x_last = XW'(FB_W - 1);
    y_last = YW'(FB_H - 1);
    if (state != S_CLEAR) begin
      case (mode_q)
        MODE_COPY: begin
          x_last = XW'(IMG_W - 1);
          y_last = YW'(IMG_H - 1);
        end
        MODE_NEAR, MODE_LERP: begin
          x_last = XW'(2 * IMG_W - 1);
          y_last = YW'(2 * IMG_H - 1);
        end
        default: begin
          x_last = XW'(IMG_W / 2 - 1);
          y_last = YW'(IMG_H / 2 - 1);
        end
      endcase
    end
  end

  coord_counter #(
    .XW(XW),
    .YW(YW)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .step   (cnt_step),
    .x_last (x_last),
    .y_last (y_last),
    .x      (cnt_x),
    .y      (cnt_y),
    .last   (cnt_last)
  );

  // Map output coordinate to source and destination coordinates.
  always_comb begin
    ox   = 32'(cnt_x);
    oy   = 32'(cnt_y);
    sx   = ox;
    sy   = oy;
    dx   = ox + CP_OX;
    dy   = oy + CP_OY;
    zoom = 1'b0;
    case (mode_q)
      MODE_NEAR, MODE_LERP: begin
        sx   = ox >> 1;
        sy   = oy >> 1;
        dx   = ox;
        dy   = oy;
        zoom = 1'b1;
      end
      MODE_AVG: begin
        sx = ox << 1;
        sy = oy << 1;
        dx = ox + AV_OX;
        dy = oy + AV_OY;
      end
      default: ;
    endcase
  end

  assign dst      = WADDR_W'(dy * FB_W + dx);
  assign clr_addr = WADDR_W'(oy * FB_W + ox);

  assign base_read_addr = run ? RADDR_W'(sy * IMG_W + sx) : '0;
  assign edge_x  = run && (sx == SX_LAST);
  assign edge_y  = run && (sy == SY_LAST);
  assign phase_x = run && zoom && cnt_x[0];
  assign phase_y = run && zoom && cnt_y[0];

  // Control FSM: accept start, clear, scan, drain the datapath, pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= MODE_COPY;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode_e'(mode);
            state  <= needs_clear(mode_e'(mode)) ? S_CLEAR : S_RUN;
          end
        end
        S_CLEAR: begin
          if (cnt_last) state <= S_RUN;
        end
        S_RUN: begin
          if (cnt_last) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(PIPE_LAT - 1)) state <= S_DONE;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delay write valid and destination to line up with datapath output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pa[i] <= '0;
    end else begin
      pv[0] <= run;
      pa[0] <= dst;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  assign fill_zero  = (state == S_CLEAR);
  assign wren       = fill_zero || pv[PIPE_LAT-1];
  assign write_addr = fill_zero ? clr_addr :
                      (pv[PIPE_LAT-1] ? pa[PIPE_LAT-1] : '0);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_resize_sequencer.sv
// Randomized bench for resize_sequencer at reduced frame size,
// compared cycle by cycle against a timeline model.
module tb_resize_sequencer;

  localparam int IW  = 20;
  localparam int IH  = 14;
  localparam int FW  = 40;
  localparam int FH  = 28;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] base_read_addr;
  logic        edge_x, edge_y, phase_x, phase_y;
  logic        wren;
  logic [16:0] write_addr;
  logic        fill_zero, busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] ra;
    logic        ex, ey, px, py, we;
    logic [16:0] wa;
    logic        fz, bz, dn;
  } obs_t;

  resize_sequencer #(
    .IMG_W(IW), .IMG_H(IH), .FB_W(FW), .FB_H(FH), .PIPE_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .base_read_addr(base_read_addr),
    .edge_x(edge_x), .edge_y(edge_y),
    .phase_x(phase_x), .phase_y(phase_y),
    .wren(wren), .write_addr(write_addr),
    .fill_zero(fill_zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, longint got, longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic void dims(input int m, output int ow, output int oh,
                               output int offx, output int offy);
    case (m)
      0: begin ow = IW; oh = IH; offx = (FW-IW)/2; offy = (FH-IH)/2; end
      1, 2: begin ow = 2*IW; oh = 2*IH; offx = 0; offy = 0; end
      default: begin
        ow = IW/2; oh = IH/2;
        offx = (FW-ow)/2; offy = (FH-oh)/2;
      end
    endcase
  endfunction

  function automatic int clear_len(int m);
    return (m == 0 || m == 3) ? FW*FH : 0;
  endfunction

  function automatic int frame_len(int m);
    int ow, oh, ox, oy;
    dims(m, ow, oh, ox, oy);
    return clear_len(m) + ow*oh + LAT + 1;
  endfunction

  // Expected outputs k cycles after the accepting edge (k=1 first busy cycle).
  function automatic obs_t model(int m, int k);
    obs_t e;
    int ow, oh, offx, offy, c, n, t, i, j, ox, oy, sx, sy;
    e = '0;
    dims(m, ow, oh, offx, offy);
    c = clear_len(m);
    n = ow*oh;
    t = c + n + LAT + 1;
    if (k >= 1 && k <= t) begin
      e.bz = 1'b1;
      e.dn = (k == t);
    end
    if (k >= 1 && k <= c) begin
      e.we = 1'b1;
      e.fz = 1'b1;
      e.wa = 17'(k-1);
    end
    i = k - c - 1;
    if (i >= 0 && i < n) begin
      ox = i % ow;
      oy = i / ow;
      case (m)
        0: begin sx = ox; sy = oy; end
        1, 2: begin sx = ox/2; sy = oy/2; end
        default: begin sx = 2*ox; sy = 2*oy; end
      endcase
      e.ra = 16'(sy*IW + sx);
      e.ex = (sx == IW-1);
      e.ey = (sy == IH-1);
      e.px = (m == 1 || m == 2) && (ox % 2 == 1);
      e.py = (m == 1 || m == 2) && (oy % 2 == 1);
    end
    j = k - c - 1 - LAT;
    if (j >= 0 && j < n) begin
      e.we = 1'b1;
      e.wa = 17'((j/ow + offy)*FW + j%ow + offx);
    end
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.ra = base_read_addr;
    o.ex = edge_x;  o.ey = edge_y;
    o.px = phase_x; o.py = phase_y;
    o.we = wren;    o.wa = write_addr;
    o.fz = fill_zero;
    o.bz = busy;    o.dn = done;
    return o;
  endfunction

  task automatic run_frame(int m, bit noise, bit start_on_done);
    int t, errs, first_bad, nw, nz, dones, first_wa, last_wa;
    int ow, oh, offx, offy;
    obs_t o, e;
    dims(m, ow, oh, offx, offy);
    t = frame_len(m);
    errs = 0; first_bad = -1; nw = 0; nz = 0; dones = 0;
    first_wa = -1; last_wa = -1;
    @(negedge clk);
    mode = 2'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= t + 2; k++) begin
      o = observe();
      e = model(m, k);
      if (o !== e) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
      if (o.we && o.fz) nz++;
      if (o.we && !o.fz) begin
        nw++;
        if (first_wa < 0) first_wa = int'(o.wa);
        last_wa = int'(o.wa);
      end
      if (o.dn) dones++;
      if (k < t) begin
        start = noise && ($urandom_range(0, 15) == 0);
        mode  = noise ? 2'($urandom) : 2'(m);
      end else if (k == t) begin
        start = start_on_done;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    mode = 2'(m);
    check($sformatf("trace m%0d first_cycle=%0d", m, first_bad), errs, 0);
    check($sformatf("data_writes m%0d", m), nw, ow*oh);
    check($sformatf("zero_writes m%0d", m), nz, clear_len(m));
    check($sformatf("first_wa m%0d", m), first_wa, offy*FW + offx);
    check($sformatf("last_wa m%0d", m), last_wa,
          (offy + oh - 1)*FW + offx + ow - 1);
    check($sformatf("dones m%0d", m), dones, 1);
  endtask

  function automatic longint all_out();
    return longint'({base_read_addr, edge_x, edge_y, phase_x, phase_y,
                     wren, write_addr, fill_zero, busy, done});
  endfunction

  task automatic reset_mid_run(int m, int at_write);
    int nw, quiet;
    nw = 0;
    @(negedge clk);
    mode = 2'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < frame_len(m) && nw < at_write; k++) begin
      if (wren && !fill_zero) nw++;
      if (nw < at_write) @(negedge clk);
    end
    check("rst_reach", nw, at_write);
    reset = 1'b1;
    #1;
    check("rst_async_out", all_out(), 0);
    @(negedge clk);
    check("rst_hold_out", all_out(), 0);
    reset = 1'b0;
    quiet = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wren || busy) quiet++;
    end
    check("rst_no_write", quiet, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out", all_out(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_out", all_out(), 0);

    run_frame(1, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0);
    run_frame(3, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b1);

    reset_mid_run(1, 500);
    run_frame(1, 1'b0, 1'b0);

    for (int f = 0; f < 6; f++)
      run_frame(int'($urandom_range(0, 3)), 1'b1, 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
